// File: rtl/riscV_lsu_pkg.sv
// Shared types and helpers for the load/store unit: size codes, FSM states,
// byte-enable patterns and the latched transaction record.
package riscV_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_RESP,
        LSU_DONE
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  size;
        logic [29:0] word;
        logic [1:0]  off;
        logic [3:0]  be;
        logic [31:0] wdata;
    } lsu_txn_t;

    // Byte offset inside the word; bits below the access size are dropped.
    function automatic logic [1:0] lsu_offset(input logic [2:0] size, input logic [1:0] a);
        case (size)
            LDST_B, LDST_BU: return a;
            LDST_H, LDST_HU: return {a[1], 1'b0};
            default:         return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_B, LDST_BU: return BE_BYTE << off;
            LDST_H, LDST_HU: return BE_HALF << off;
            default:         return BE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [2:0] size, input logic [31:0] d);
        case (size)
            LDST_B, LDST_BU: return {4{d[7:0]}};
            LDST_H, LDST_HU: return {2{d[15:0]}};
            default:         return d;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] a);
        case (size)
            LDST_B, LDST_BU: return 1'b0;
            LDST_H, LDST_HU: return a[0];
            default:         return a != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/riscV_lsu_load_align.sv
// Moves the addressed byte/half/word of a read word to bit 0 and extends it.
module riscV_lsu_load_align
    import riscV_lsu_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        data = shifted;
        case (size)
            LDST_B:  data = {{24{shifted[7]}}, shifted[7:0]};
            LDST_BU: data = {24'h0, shifted[7:0]};
            LDST_H:  data = {{16{shifted[15]}}, shifted[15:0]};
            LDST_HU: data = {16'h0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Execute-stage load/store unit: req/gnt/rvalid data-memory FSM with stall.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned H/W accesses instead of issuing them.
module riscv_lsu
    import riscV_lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_misaligned_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    lsu_state_e  state_q, state_d;
    lsu_txn_t    txn_q, txn_d;
    logic [31:0] ldata_q, ldata_ext;
    logic        load_en;
    logic        req_mis;
    logic [1:0]  req_off;

`ifdef LSU_MISALIGN_CHECK_EN
    logic mis_q;

    assign req_mis = lsu_misaligned(lsu_size_i, lsu_addr_i[1:0]);

    // Only set on the IDLE->DONE hop, so it is high for exactly the DONE cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) mis_q <= 1'b0;
        else       mis_q <= (state_q == LSU_IDLE) && lsu_req_i && req_mis;
    end

    assign lsu_misaligned_o = mis_q;
`else
    assign req_mis          = 1'b0;
    assign lsu_misaligned_o = 1'b0;
`endif

    assign req_off = lsu_offset(lsu_size_i, lsu_addr_i[1:0]);

    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        load_en = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (lsu_req_i) begin
                    txn_d.we    = lsu_we_i;
                    txn_d.size  = lsu_size_i;
                    txn_d.word  = lsu_addr_i[31:2];
                    txn_d.off   = req_off;
                    txn_d.be    = lsu_be(lsu_size_i, req_off);
                    txn_d.wdata = lsu_wdata(lsu_size_i, lsu_data_i);
                    state_d     = req_mis ? LSU_DONE : LSU_REQ;
                end
            end
            LSU_REQ: begin
                if (data_gnt_i) state_d = txn_q.we ? LSU_DONE : LSU_RESP;
            end
            LSU_RESP: begin
                if (data_rvalid_i) begin
                    load_en = 1'b1;
                    state_d = LSU_DONE;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LSU_IDLE;
            txn_q   <= '0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
            if (load_en) ldata_q <= ldata_ext;
        end
    end

    riscV_lsu_load_align u_align (
        .size  (txn_q.size),
        .off   (txn_q.off),
        .rdata (data_rdata_i),
        .data  (ldata_ext)
    );

    assign lsu_data_o      = ldata_q;
    assign lsu_stall_req_o = ((state_q == LSU_IDLE) && lsu_req_i) ||
                             (state_q == LSU_REQ) || (state_q == LSU_RESP);
    assign data_req_o      = (state_q == LSU_REQ);
    assign data_we_o       = txn_q.we;
    assign data_be_o       = txn_q.be;
    assign data_addr_o     = {txn_q.word, 2'b00};
    assign data_wdata_o    = txn_q.wdata;

endmodule

// File: doc/riscv_lsu.md
# riscV_lsu

Load/store unit in the execute stage of the RISC-V core, directly downstream of `riscV_alu`. It takes the ALU `result_o` as the effective address, together with store data and access size from the decoder. It runs a multi-cycle request/grant/response transaction on the data-memory port and returns aligned, sign/zero-extended load data. While a transaction is in flight it stalls the pipeline.

## Interface
- No parameters; address and data widths are fixed at 32.
- `clk_i` in 1 — core clock; all state changes on its rising edge.
- `rst_i` in 1 — reset; synchronous and active-high.
- `lsu_req_i` in 1 — memory instruction in execute; held with its operands while `lsu_stall_req_o`=1.
- `lsu_we_i` in 1 — 1 = store, 0 = load.
- `lsu_size_i` in 3 — funct3 encoding: B=0, H=1, W=2, BU=4, HU=5; codes 3, 6, 7 are treated as W.
- `lsu_addr_i` in 32 — effective address from ALU `result_o`.
- `lsu_data_i` in 32 — store data (rs2).
- `lsu_data_o` out 32 — extended load data, registered.
- `lsu_stall_req_o` out 1 — pipeline stall request.
- `lsu_misaligned_o` out 1 — one-cycle misaligned-access flag.
- `data_req_o` out 1 — memory request.
- `data_we_o` out 1 — memory write enable.
- `data_be_o` out 4 — byte enables.
- `data_addr_o` out 32 — word address: `{addr[31:2],2'b00}`.
- `data_wdata_o` out 32 — replicated store data.
- `data_gnt_i` in 1 — memory accepted the request.
- `data_rvalid_i` in 1 — read data valid.
- `data_rdata_i` in 32 — read data word.

## Operation
- FSM states are IDLE, REQ, RESP, DONE.
- **IDLE:**
  - When `lsu_req_i`=1, latch we, size, address, byte enables and write data into internal registers, then go to REQ.
  - With misaligned checking enabled and a misaligned access, go to DONE instead.
- **REQ:**
  - `data_req_o`=1, driven from the latched registers; hold until `data_gnt_i`=1.
  - On grant: a store goes to DONE, a load goes to RESP.
- **RESP:**
  - Wait for `data_rvalid_i`=1.
  - Then register the extracted data into `lsu_data_o` and go to DONE.
- **DONE:** lasts exactly one cycle, then IDLE. `lsu_stall_req_o`=0 in this cycle so the core advances.
- `lsu_stall_req_o` = (IDLE & `lsu_req_i`) | REQ | RESP.
- Byte enables:
  - B/BU: `4'b0001 << addr[1:0]`.
  - H/HU: `4'b0011 << {addr[1],1'b0}`.
  - W: `4'b1111`.
- Write data:
  - B: `{4{d[7:0]}}`.
  - H: `{2{d[15:0]}}`.
  - W: `d`.
- Load extraction:
  - Shift `rdata` right by `addr[1:0]*8`.
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W is passed through.
- Dropping `lsu_req_i` in REQ or RESP does not abort; the transaction completes.
- `data_rvalid_i` outside RESP is ignored. `data_gnt_i` outside REQ is ignored.
- On a store, `lsu_data_o` keeps its previous value.

## Timing
- Reset:
  - State goes to IDLE.
  - `lsu_data_o`=0, `data_req_o`=0, `data_we_o`=0, `data_be_o`=0, `data_addr_o`=0, `data_wdata_o`=0.
  - `lsu_misaligned_o`=0; `lsu_stall_req_o`=0 unless `lsu_req_i`=1.
- Reset in REQ or RESP abandons the transaction. A late `data_rvalid_i` after reset is ignored.
- Store with immediate grant: request in c0, `data_req_o` in c1, DONE in c2. Stall is high in c0–c1, low in c2.
- Load with grant in c1 and rvalid in c2: `lsu_data_o` is valid from c3 (DONE), which is 3 cycles of stall.
- Each wait cycle on grant or rvalid adds one stall cycle.
- Back-to-back accesses: IDLE sees the next request in the cycle after DONE.

## Configuration
- Macro: `LSU_MISALIGN_CHECK_EN`.
- **Defined:**
  - H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0, issues no bus request.
  - The FSM goes IDLE→DONE; `lsu_misaligned_o`=1 during DONE; `lsu_data_o` is unchanged.
- **Undefined:**
  - `lsu_misaligned_o` is tied to 0.
  - Low address bits below the access size are ignored: H uses `addr[1]` only, W uses the word address.

## Structure
- Package `riscV_lsu_pkg` holds:
  - Size codes `LDST_B`/`LDST_H`/`LDST_W`/`LDST_BU`/`LDST_HU`.
  - The FSM state enum.
  - The byte-enable constants.
- Sub-module `riscV_lsu_load_align`: combinational rdata shift plus extension, driven by size and `addr[1:0]`.

## Test plan
- SB: addr=0x1003, data=0xAABBCCDD, gnt in c1 → `be`=4'b1000, `wdata`=0xDDDDDDDD, `data_addr_o`=0x1000; stall high 2 cycles, low in DONE.
- LB vs LBU at addr=0x2001, rdata=0x0000_8000 → LB gives 0xFFFFFF80, LBU gives 0x00000080.
- LH at addr=0x2002, rdata=0x8001_0000, gnt delayed 3 cycles, rvalid 2 cycles after gnt → `lsu_data_o`=0xFFFF8001; stall lasts 7 cycles.
- LW at addr=0x3002:
  - With macro: no `data_req_o`, `lsu_misaligned_o`=1 for 1 cycle.
  - Without macro: `data_addr_o`=0x3000, `be`=4'b1111.
- `rst_i` asserted in RESP, then rvalid=1 with rdata=0x12345678 → state IDLE, `lsu_data_o`=0, no stall.
- SW then LW back-to-back, same addr=0x4000, memory model → load returns the stored 0xCAFEBABE; second request accepted the cycle after DONE.
